// File: rtl/stream_req_gen_pkg.sv
// Shared defaults and per-stream state layout for the stream request generator.
package stream_req_gen_pkg;

  localparam int NSTRMS     = 64;
  localparam int STRM_NCL   = 4;
  localparam int CL_BYTES   = 128;
  localparam int ADDR_WIDTH = 64;
  localparam int CNT_WIDTH  = 32;
  localparam int CRD_WIDTH  = $clog2(STRM_NCL + 1);

  // Per-stream state at the default configuration; the top re-declares the
  // same layout sized by its own parameters.
  typedef struct packed {
    logic                  active;
    logic [ADDR_WIDTH-1:0] ea;
    logic [CNT_WIDTH-1:0]  rem;
    logic [CRD_WIDTH-1:0]  crd;
  } strm_state_t;

endpackage

// File: rtl/stream_rr_arb.sv
// n-way round-robin arbiter: first eligible index at or after rr_i, wrapping.
module stream_rr_arb
  import stream_req_gen_pkg::*;
#(
  parameter  int n = NSTRMS,
  localparam int w = $clog2(n)
) (
  input  logic [n-1:0] elig_i,
  input  logic [w-1:0] rr_i,
  output logic         gnt_v_o,
  output logic [w-1:0] gnt_idx_o
);

  // NOTE: outputs get defaults before the loop so no path leaves them unassigned (no latch).
  always_comb begin
    gnt_v_o   = 1'b0;
    gnt_idx_o = '0;
    // Walk from the farthest candidate back to rr_i so the nearest one wins.
    for (int k = n - 1; k >= 0; k--) begin
      if (elig_i[(int'(rr_i) + k) % n]) begin
        gnt_v_o   = 1'b1;
        gnt_idx_o = w'((int'(rr_i) + k) % n);
      end
    end
  end

endmodule

// File: rtl/stream_req_gen.sv
// Multi-stream line request generator with per-stream credits and a
// round-robin arbitrated, single-entry registered request output.
module stream_req_gen
  import stream_req_gen_pkg::*;
#(
  parameter  int addr_width   = ADDR_WIDTH,
  parameter  int nstrms       = NSTRMS,
  parameter  int strm_ncl     = STRM_NCL,
  parameter  int cnt_width    = CNT_WIDTH,
  parameter  int cl_bytes     = CL_BYTES,
  localparam int nstrms_width = $clog2(nstrms),
  localparam int crd_width    = $clog2(strm_ncl + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_cfg_v,
  output logic                    i_cfg_r,
  input  logic [nstrms_width-1:0] i_cfg_sid,
  input  logic [addr_width-1:0]   i_cfg_ea,
  input  logic [cnt_width-1:0]    i_cfg_cnt,
  input  logic                    i_crd_v,
  output logic                    i_crd_r,
  input  logic [nstrms_width-1:0] i_crd_sid,
  output logic                    o_req_v,
  input  logic                    o_req_r,
  output logic [nstrms_width-1:0] o_req_sid,
  output logic [addr_width-1:0]   o_req_ea,
  output logic [nstrms-1:0]       o_busy,
  output logic                    o_err
);

  typedef struct packed {
    logic                  active;
    logic [addr_width-1:0] ea;
    logic [cnt_width-1:0]  rem;
    logic [crd_width-1:0]  crd;
  } strm_t;

  localparam logic [addr_width-1:0] LINE_MASK = ~addr_width'(cl_bytes - 1);
  localparam logic [addr_width-1:0] LINE_INC  = addr_width'(cl_bytes);
  localparam logic [crd_width-1:0]  CRD_FULL  = crd_width'(strm_ncl);

  strm_t                   st_q [nstrms];
  strm_t                   st_d [nstrms];
  logic [nstrms_width-1:0] rr_q, rr_d;
  logic                    req_v_q, req_v_d;
  logic [nstrms_width-1:0] req_sid_q, req_sid_d;
  logic [addr_width-1:0]   req_ea_q, req_ea_d;
  logic                    err_q, err_d;

  logic [nstrms-1:0]       elig, busy, cfg_hit, crd_hit, gnt_hit;
  logic                    gnt_v, grant;
  logic [nstrms_width-1:0] gnt_idx;

  always_comb begin
    for (int i = 0; i < nstrms; i++) begin
      cfg_hit[i] = i_cfg_v && (i_cfg_sid == nstrms_width'(i));
      crd_hit[i] = i_crd_v && (i_crd_sid == nstrms_width'(i));
      busy[i]    = st_q[i].active;
      elig[i]    = st_q[i].active && (st_q[i].rem != '0) && (st_q[i].crd != '0) && !cfg_hit[i];
    end
  end

  stream_rr_arb #(.n(nstrms)) u_arb (
    .elig_i    (elig),
    .rr_i      (rr_q),
    .gnt_v_o   (gnt_v),
    .gnt_idx_o (gnt_idx)
  );

  // The output register may take a new grant while its current entry drains.
  assign grant = gnt_v && (!req_v_q || o_req_r);

  always_comb begin
    for (int i = 0; i < nstrms; i++) begin
      gnt_hit[i] = grant && (gnt_idx == nstrms_width'(i));
    end
  end

  always_comb begin
    err_d     = err_q;
    rr_d      = rr_q;
    req_v_d   = req_v_q;
    req_sid_d = req_sid_q;
    req_ea_d  = req_ea_q;
    if (grant) begin
      req_v_d   = 1'b1;
      req_sid_d = gnt_idx;
      req_ea_d  = st_q[gnt_idx].ea;
      rr_d      = (gnt_idx == nstrms_width'(nstrms - 1)) ? '0 : gnt_idx + nstrms_width'(1);
    end else if (o_req_r) begin
      req_v_d = 1'b0;
    end

    for (int i = 0; i < nstrms; i++) begin
      st_d[i] = st_q[i];
      if (gnt_hit[i]) begin
        st_d[i].ea  = st_q[i].ea + LINE_INC;
        st_d[i].rem = st_q[i].rem - cnt_width'(1);
        if (st_q[i].rem == cnt_width'(1)) st_d[i].active = 1'b0;
      end
      // A credit and a grant on the same stream cancel, even at full credit.
      if (crd_hit[i] && !gnt_hit[i]) begin
        if (st_q[i].crd == CRD_FULL) err_d = 1'b1;
        else                         st_d[i].crd = st_q[i].crd + crd_width'(1);
      end else if (gnt_hit[i] && !crd_hit[i]) begin
        st_d[i].crd = st_q[i].crd - crd_width'(1);
      end
      if (cfg_hit[i]) begin
        if (i_cfg_cnt != '0) begin
          st_d[i].active = 1'b1;
          st_d[i].ea     = i_cfg_ea & LINE_MASK;
          st_d[i].rem    = i_cfg_cnt;
        end else begin
          st_d[i].active = 1'b0;
        end
      end
    end
  end

  // NOTE: the per-stream table is plain flops, so every entry is reset explicitly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < nstrms; i++) begin
        st_q[i] <= '{active: 1'b0, ea: '0, rem: '0, crd: CRD_FULL};
      end
      rr_q      <= '0;
      req_v_q   <= 1'b0;
      req_sid_q <= '0;
      req_ea_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      for (int i = 0; i < nstrms; i++) begin
        st_q[i] <= st_d[i];
      end
      rr_q      <= rr_d;
      req_v_q   <= req_v_d;
      req_sid_q <= req_sid_d;
      req_ea_q  <= req_ea_d;
      err_q     <= err_d;
    end
  end

  assign i_cfg_r   = 1'b1;
  assign i_crd_r   = 1'b1;
  assign o_req_v   = req_v_q;
  assign o_req_sid = req_sid_q;
  assign o_req_ea  = req_ea_q;
  assign o_busy    = busy;
  assign o_err     = err_q;

endmodule

// File: doc/stream_req_gen.md
STREAM_REQ_GEN -- requirements
Module: stream_req_gen

Interface
REQ-001 SHALL have parameter addr_width, default 64, effective-address width.
REQ-002 SHALL have parameter nstrms, default 64, number of streams; nstrms_width = $clog2(nstrms).
REQ-003 SHALL have parameter strm_ncl, default 4, L2 lines per stream, i.e. the maximum outstanding requests per stream; crd_width = $clog2(strm_ncl+1).
REQ-004 SHALL have parameter cnt_width, default 32, width of the line count.
REQ-005 SHALL have parameter cl_bytes, default 128, bytes per cache line; this is a power of 2.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 i_cfg_v / i_cfg_r  in / out  1 / 1  stream-start handshake.
REQ-009 i_cfg_sid / i_cfg_ea / i_cfg_cnt  in  nstrms_width / addr_width / cnt_width  stream id, line-aligned base EA, number of lines.
REQ-010 i_crd_v / i_crd_r  in / out  1 / 1  credit return, one line consumed.
REQ-011 i_crd_sid  in  nstrms_width  stream receiving the credit.
REQ-012 o_req_v / o_req_r  out / in  1 / 1  request handshake towards the tag interface.
REQ-013 o_req_sid / o_req_ea  out  nstrms_width / addr_width  request stream id and line EA.
REQ-014 o_busy  out  nstrms  per-stream active flag.
REQ-015 o_err  out  1  sticky credit-overflow flag.

Function
REQ-016 Per-stream state SHALL be: active flag, next EA, remaining count (cnt_width), credits (crd_width).
REQ-017 i_cfg_r and i_crd_r SHALL be tied to 1.
REQ-018 A cfg handshake with cnt > 0 SHALL set active, next EA = i_cfg_ea and remaining = i_cfg_cnt.
  - Credits are left unchanged, because lines may still be in flight.
  - A cfg to an active stream restarts that stream.
REQ-019 A cfg handshake with cnt = 0 SHALL clear active for that stream.
REQ-020 A stream SHALL be eligible when active, remaining > 0, credits > 0, and it is not the target of a cfg in the same cycle.
REQ-021 Arbitration SHALL be round-robin over eligible streams.
  - Search starts at pointer rr.
  - After a grant to stream g, rr = (g+1) mod nstrms.
  - With no grant, rr holds.
REQ-022 A grant SHALL occur only when the output register is empty or is being emptied (o_req_v & o_req_r) in the same cycle; at most one grant per cycle.
REQ-023 On grant SHALL load the output register with {g, next EA[g]}.
  - next EA += cl_bytes, modulo 2^addr_width.
  - remaining -= 1; credits -= 1.
  - When remaining reaches 0, clear active.
REQ-024 The output register SHALL hold its data stable while o_req_v=1 and o_req_r=0.
REQ-025 A credit return SHALL increment credits[i_crd_sid].
  - A credit and a grant on the same stream in the same cycle SHALL leave credits unchanged (net 0).
REQ-026 A credit return to a stream already at strm_ncl, with no simultaneous grant on it, SHALL be dropped and SHALL set o_err; o_err stays set until reset.
REQ-027 Latency: cfg handshake at cycle n -> earliest o_req_v=1 at cycle n+2 (one cycle to arbitrate, one registered output stage).
REQ-028 Throughput SHALL be one request per cycle while o_req_r=1 and an eligible stream exists.
REQ-029 o_busy[i] SHALL equal active[i] registered; it SHALL be 0 once the last line of stream i is granted.
REQ-030 The bits of i_cfg_ea below log2(cl_bytes) SHALL be ignored (treated as 0).

Reset
REQ-031 While reset=0, all state SHALL be asynchronously forced:
  - active = 0, remaining = 0, next EA = 0, credits = strm_ncl, rr = 0.
  - o_req_v = 0, o_req_sid = 0, o_req_ea = 0, o_busy = 0, o_err = 0.
REQ-032 Reset asserted mid-operation SHALL abandon all pending and registered requests; no request SHALL be presented in the first cycle after reset deassertion.

Structure
REQ-033 A shared package SHALL hold the default parameters (nstrms, strm_ncl, cl_bytes, addr_width) and the per-stream state struct typedef.
REQ-034 SHALL instantiate one sub-module, stream_rr_arb: an nstrms-way round-robin arbiter taking an eligibility vector and the rr pointer, returning a grant valid bit and the grant index.

Verification
REQ-035 Reset, then cfg sid=3, ea=0x1000, cnt=2, o_req_r=1 -> requests (3,0x1000) at cfg+2 and (3,0x1080) at cfg+3; o_busy[3] falls after the second grant.
REQ-036 Cfg sid=0 cnt=10, no credits returned -> exactly 4 requests, then o_req_v=0; one credit for sid 0 -> exactly 1 further request, EA 0x200 above base.
REQ-037 Cfg sids 1, 2, 5 each with cnt=3 -> grant order 1,2,5,1,2,5,1,2,5.
REQ-038 Hold o_req_r=0 for 5 cycles with a request pending -> o_req_sid and o_req_ea stable, no extra grants, credits decremented only once.
REQ-039 Credit to an idle stream with full credits -> o_err=1 and stays 1; a credit plus grant on the same stream in one cycle -> credits unchanged.
REQ-040 Cfg ea=0xFFFF_FFFF_FFFF_FF80, cnt=2 -> EAs 0xFFFF_FFFF_FFFF_FF80 then 0x0; reset asserted mid-stream -> o_req_v=0 immediately, o_busy=0.
